// File: rtl/palette_pkg.sv
// Shared types and defaults for the palette arbiter.
package palette_pkg;

  // 12-bit colour as read from the palette ROM, red in the top nibble.
  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

  typedef logic [7:0] pal_index_t;

  localparam pal_index_t TRANSPARENT_IDX_DEFAULT = 8'h00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, circularly.
module rr_arbiter
  import palette_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  int unsigned idx;
  logic        found;

  // Scan offsets 0..N-1 from ptr; the first hit wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/palette_arbiter.sv
// Shares one combinational palette ROM among N_REQ pixel requesters; one lookup per clock,
// registered response tagged with the requester ID.
module palette_arbiter
  import palette_pkg::*;
#(
  parameter int unsigned N_REQ           = 4,
  parameter pal_index_t  TRANSPARENT_IDX = TRANSPARENT_IDX_DEFAULT,
  parameter int unsigned IDW             = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*8-1:0]   req_index,
  output logic [N_REQ-1:0]     req_ready,
  output pal_index_t           pal_index,
  input  rgb12_t               pal_rgb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output rgb12_t               rsp_rgb,
  output logic                 rsp_transparent
);

  logic [IDW-1:0] rr_ptr;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;
  logic           free;

  // Slot is free when empty or being drained this cycle; Reset masks grants combinationally.
  assign free    = !rsp_valid || rsp_ready;
  assign gnt_any = |gnt;
  assign req_ready = gnt;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .en     (free && !Reset),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Route the granted requester's index to the ROM; zero when idle.
  always_comb begin
    pal_index = 8'h00;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) pal_index = req_index[i*8 +: 8];
    end
  end

  // Response register and round-robin pointer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_rgb         <= '0;
      rsp_transparent <= 1'b0;
      rr_ptr          <= '0;
    end else if (gnt_any) begin
      rsp_valid       <= 1'b1;
      rsp_id          <= gnt_id;
      rsp_rgb         <= pal_rgb;
      rsp_transparent <= (pal_index == TRANSPARENT_IDX);
      rr_ptr          <= (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/palette_arbiter.md
# palette_arbiter

Round-robin arbiter that shares one combinational 256-entry palette ROM among several pixel requesters, such as the background, tank and bullet sprite fetchers. It accepts at most one 8-bit colour index per clock and drives it onto the palette address. The 12-bit RGB result is registered and returned on a single response channel, tagged with the requester ID. It sits between the sprite-fetch units and the VGA colour mux.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- TRANSPARENT_IDX, 8'h00, palette index treated as "no pixel"

Ports:
- Clk  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  requester i has an index pending
- req_index  in  N_REQ*8  index of requester i at bits [8i+7:8i]
- req_ready  out  N_REQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- pal_index  out  8  address to palette ROM
- pal_rgb  in  12  {red,green,blue} from palette ROM, combinational in pal_index
- rsp_valid  out  1  response register holds data
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  requester ID of response; IDW = max(1, clog2(N_REQ))
- rsp_rgb  out  12  registered colour
- rsp_transparent  out  1  index was TRANSPARENT_IDX

## Operation
- Slot free condition: free = !rsp_valid | rsp_ready.
- Grant rule:
  - When free, choose the first i with req_valid[i] = 1, searching circularly from rr_ptr.
  - req_ready = onehot(i). req_ready = 0 when not free or no request.
  - req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Palette drive: pal_index = req_index of the granted requester. When nothing is granted, pal_index = 8'h00.
- Capture on grant, at the clock edge:
  - rsp_rgb <= pal_rgb
  - rsp_id <= i
  - rsp_transparent <= (index == TRANSPARENT_IDX)
  - rsp_valid <= 1
  - rr_ptr <= (i+1) mod N_REQ. Wrap from N_REQ-1 back to 0.
- Drain without new grant: rsp_ready & rsp_valid with no grant gives rsp_valid <= 0. rr_ptr is unchanged.
- Simultaneous drain and grant: the response register is overwritten. rsp_valid stays 1.
- Stall: when rsp_valid & !rsp_ready:
  - all req_ready = 0
  - rsp_* hold stable
  - rr_ptr holds
- Requester behaviour: a requester holding req_valid with a fixed index must not change that index until it is granted. The arbiter does not check this.
- Starvation bound: a continuously valid requester is granted within N_REQ accepted transfers.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_rgb=12'h000, rsp_transparent=0, rr_ptr=0.
- Combinational outputs during reset: req_ready=0 and pal_index=8'h00 while Reset is high.
- Latency: a grant in cycle t makes the response visible in cycle t+1.
- Throughput: 1 lookup/clock while rsp_ready=1.
- Reset mid-operation: the pending response is dropped immediately (asynchronous). No request is lost from the requester's view, because it is held until a grant after reset.
- State: the only state is rr_ptr, the response register and rsp_valid. There is no FSM beyond the valid bit; the pipeline is one stage deep.

## Structure
- Package palette_pkg:
  - rgb12_t (struct of three 4-bit channels)
  - pal_index_t (8-bit)
  - TRANSPARENT_IDX_DEFAULT
- Sub-module rr_arbiter (parameter N):
  - Inputs: request vector, rr_ptr, enable.
  - Outputs: one-hot grant and binary grant ID.
  - Purely combinational.
- palette_arbiter holds rr_ptr, the index mux and the response register.
- The palette ROM is instantiated outside and connected through pal_index/pal_rgb.

## Test plan
- Reset with all req_valid=1 → req_ready=0 and rsp_valid=0. After release, the first grant goes to req 0. The next cycle gives rsp_valid=1, rsp_id=0, and rsp_rgb equal to the palette entry for req_index[7:0].
- All four requesters valid, rsp_ready=1, held 8 cycles → grant order 0,1,2,3,0,1,2,3. Exactly one rsp per cycle, each with the matching ID and RGB.
- Only req 3 then req 1 valid, starting with rr_ptr=0 → req 3 is granted, rr_ptr=0, and req 1 is granted the following cycle.
- rsp_ready=0 for 3 cycles with requests pending → req_ready=0. rsp_id/rsp_rgb are stable across all 3 cycles. When rsp_ready rises, the drain and the new grant occur in the same cycle.
- req_index=8'h00 → rsp_transparent=1. req_index=8'h08 → rsp_transparent=0 with rsp_rgb matching the palette entry.
- Assert Reset asynchronously mid-cycle while rsp_valid=1 → rsp_valid falls without waiting for a clock edge. rr_ptr returns to 0.
